// File: rtl/pr_elastic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pr_elastic_pkg
//  Description : Shared defaults and helpers for the pr_elastic pipeline
//                register family.
//  Revision    : 1.0 - initial release
// ============================================================================
package pr_elastic_pkg;

    localparam int PR_DATA_W_DEFAULT = 32;
    localparam int PR_DEPTH_DEFAULT  = 1;

    // Occupancy counter width: must hold 0 .. DEPTH+1 (slots plus skid).
    function automatic int pr_cnt_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pr_elastic_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pr_elastic_slot
//  Description : One valid+payload register of the elastic pipeline. Payload
//                is only captured when the incoming entry is valid, so a
//                bubble never drags stray data into the slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module pr_elastic_slot
    import pr_elastic_pkg::*;
#(
    parameter int DATA_W = PR_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              src_valid_i,
    input  logic [DATA_W-1:0] src_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Flush clears only the valid bit and beats any load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= src_valid_i;
            if (src_valid_i) begin
                data_q <= src_data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pr_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : pr_elastic
//  Description : Parametrised elastic pipeline register with valid/ready
//                handshakes, bubble collapsing, optional input skid buffer,
//                single-cycle flush, occupancy count and a sticky protocol
//                checker on the input port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pr_elastic
    import pr_elastic_pkg::*;
#(
    parameter int DATA_W = PR_DATA_W_DEFAULT,
    parameter int DEPTH  = PR_DEPTH_DEFAULT,
    parameter int SKID   = 1,
    parameter int CNT_W  = pr_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  occupancy,
    output logic              overflow_err
);

    logic [DEPTH-1:0]             slot_v;
    logic [DEPTH-1:0][DATA_W-1:0] slot_d;
    logic [DEPTH-1:0]             adv;
    logic                         in_fire;
    logic                         out_fire;
    logic                         src_valid;
    logic [DATA_W-1:0]            src_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Advance chain: a slot may load if it is empty or the slot after it moves.
    always_comb begin
        adv          = '0;
        adv[DEPTH-1] = !slot_v[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !slot_v[i] | adv[i+1];
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic              src_v;
            logic [DATA_W-1:0] src_d;
            if (i == 0) begin : g_head
                assign src_v = src_valid;
                assign src_d = src_data;
            end else begin : g_body
                assign src_v = slot_v[i-1];
                assign src_d = slot_d[i-1];
            end
            pr_elastic_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .load_i      (adv[i]),
                .flush_i     (flush),
                .src_valid_i (src_v),
                .src_data_i  (src_d),
                .valid_o     (slot_v[i]),
                .data_o      (slot_d[i])
            );
        end

        if (SKID == 1) begin : g_skid
            logic              skid_valid_q;
            logic              skid_valid_d;
            logic              in_ready_q;
            logic              skid_load;
            logic [DATA_W-1:0] skid_data_q;

            // Accepted input parks in the skid when stage 0 cannot take it;
            // the skid drains into stage 0 ahead of any new input.
            always_comb begin
                skid_load    = in_fire & !adv[0];
                skid_valid_d = skid_valid_q;
                if (flush) begin
                    skid_valid_d = 1'b0;
                end else if (skid_valid_q && adv[0]) begin
                    skid_valid_d = 1'b0;
                end else if (skid_load) begin
                    skid_valid_d = 1'b1;
                end
            end

            // Skid state and the registered in_ready derived from it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_valid_q <= 1'b0;
                    in_ready_q   <= 1'b0;
                    skid_data_q  <= '0;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    in_ready_q   <= !skid_valid_d;
                    if (skid_load) begin
                        skid_data_q <= in_data;
                    end
                end
            end

            assign in_ready  = in_ready_q;
            assign src_valid = skid_valid_q | in_fire;
            assign src_data  = skid_valid_q ? skid_data_q : in_data;
        end else begin : g_noskid
            // Without a skid, ready ripples straight through the advance chain.
            assign in_ready  = adv[0] & rst_n;
            assign src_valid = in_fire;
            assign src_data  = in_data;
        end
    endgenerate

    assign out_valid = slot_v[DEPTH-1];
    assign out_data  = slot_d[DEPTH-1];

    // Occupancy counter and input-protocol checker state.
    logic [CNT_W-1:0]  occ_q;
    logic [CNT_W-1:0]  occ_d;
    logic              stall_q;
    logic [DATA_W-1:0] held_q;
    logic              ovf_q;
    logic              ovf_d;

    // Next occupancy and the sticky error for a stalled request that was
    // withdrawn or whose payload changed.
    always_comb begin
        occ_d = occ_q + {{(CNT_W-1){1'b0}}, in_fire} - {{(CNT_W-1){1'b0}}, out_fire};
        if (flush) begin
            occ_d = '0;
        end
        ovf_d = ovf_q | (stall_q & (!in_valid | (in_data != held_q)));
    end

    // Counter and checker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= '0;
            stall_q <= 1'b0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            stall_q <= in_valid & !in_ready;
            held_q  <= in_data;
            ovf_q   <= ovf_d;
        end
    end

    assign occupancy    = occ_q;
    assign overflow_err = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pr_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pr_elastic
//  Description : Directed self-checking bench for pr_elastic. Three instances:
//                A (DEPTH=3, SKID=1), B (DEPTH=2, SKID=1), C (DEPTH=3, SKID=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pr_elastic;

    logic clk;
    logic rst_n;
    logic b_rst_n;
    int   total;
    int   bad;

    // Instance A
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_ovf;
    logic [31:0] a_in_data, a_out_data;
    logic [2:0]  a_occ;
    // Instance B
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_ovf;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    // Instance C
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush, c_ovf;
    logic [31:0] c_in_data, c_out_data;
    logic [2:0]  c_occ;

    pr_elastic #(.DATA_W(32), .DEPTH(3), .SKID(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .flush(a_flush), .occupancy(a_occ), .overflow_err(a_ovf)
    );
    pr_elastic #(.DATA_W(32), .DEPTH(2), .SKID(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .flush(b_flush), .occupancy(b_occ), .overflow_err(b_ovf)
    );
    pr_elastic #(.DATA_W(32), .DEPTH(3), .SKID(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .flush(c_flush), .occupancy(c_occ), .overflow_err(c_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1; b_rst_n = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0; a_flush = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_flush = 0;
        c_in_valid = 0; c_in_data = 0; c_out_ready = 0; c_flush = 0;
        #2;
        rst_n = 1'b0; b_rst_n = 1'b0;
        step();
        step();
        // ---------------- reset state ----------------
        check("rst_a_in_ready", {31'd0, a_in_ready}, 32'd0);
        check("rst_c_in_ready", {31'd0, c_in_ready}, 32'd0);
        check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_a_out_data", a_out_data, 32'd0);
        check("rst_a_occ", {29'd0, a_occ}, 32'd0);
        check("rst_a_ovf", {31'd0, a_ovf}, 32'd0);
        rst_n = 1'b1; b_rst_n = 1'b1;
        step();
        check("post_rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
        check("post_rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);
        check("post_rst_c_in_ready", {31'd0, c_in_ready}, 32'd1);
        step();

        // ---------------- latency, A ----------------
        a_out_ready = 1; a_in_valid = 1; a_in_data = 32'hA5A5_0001;
        check("lat_in_ready", {31'd0, a_in_ready}, 32'd1);
        step();
        a_in_valid = 0; a_in_data = 'x;
        check("lat_t1_valid", {31'd0, a_out_valid}, 32'd0);
        check("lat_t1_occ", {29'd0, a_occ}, 32'd1);
        step();
        check("lat_t2_valid", {31'd0, a_out_valid}, 32'd0);
        check("lat_t2_occ", {29'd0, a_occ}, 32'd1);
        step();
        check("lat_t3_valid", {31'd0, a_out_valid}, 32'd1);
        check("lat_t3_data", a_out_data, 32'hA5A5_0001);
        check("lat_t3_occ", {29'd0, a_occ}, 32'd1);
        step();
        check("lat_t4_valid", {31'd0, a_out_valid}, 32'd0);
        check("lat_t4_occ", {29'd0, a_occ}, 32'd0);

        // ---------------- flush, A ----------------
        a_out_ready = 0; a_in_valid = 1;
        a_in_data = 32'h11; check("fl_rdy0", {31'd0, a_in_ready}, 32'd1); step();
        a_in_data = 32'h22; check("fl_rdy1", {31'd0, a_in_ready}, 32'd1); step();
        a_in_data = 32'h33; check("fl_rdy2", {31'd0, a_in_ready}, 32'd1); step();
        a_in_valid = 0;
        check("fl_full_occ", {29'd0, a_occ}, 32'd3);
        check("fl_full_data", a_out_data, 32'h11);
        a_flush = 1; a_in_valid = 1; a_in_data = 32'h55; a_out_ready = 1;
        check("fl_deliver_valid", {31'd0, a_out_valid}, 32'd1);
        check("fl_deliver_data", a_out_data, 32'h11);
        step();
        a_flush = 0; a_in_valid = 0;
        check("fl_after_occ", {29'd0, a_occ}, 32'd0);
        check("fl_after_valid", {31'd0, a_out_valid}, 32'd0);
        check("fl_after_rdy", {31'd0, a_in_ready}, 32'd1);
        step();
        check("fl_dropped_valid", {31'd0, a_out_valid}, 32'd0);
        step();
        check("fl_dropped_valid2", {31'd0, a_out_valid}, 32'd0);
        check("fl_ovf", {31'd0, a_ovf}, 32'd0);

        // ---------------- sustained stream, B ----------------
        b_out_ready = 1;
        for (int k = 0; k < 16; k++) begin
            b_in_valid = 1; b_in_data = k;
            check("st_rdy", {31'd0, b_in_ready}, 32'd1);
            if (k >= 2) begin
                check("st_valid", {31'd0, b_out_valid}, 32'd1);
                check("st_data", b_out_data, k - 2);
            end
            step();
        end
        b_in_valid = 0;
        check("st_d14_data", b_out_data, 32'd14);
        step();
        check("st_d15_data", b_out_data, 32'd15);
        check("st_d15_valid", {31'd0, b_out_valid}, 32'd1);
        step();
        check("st_empty", {31'd0, b_out_valid}, 32'd0);
        check("st_empty_occ", {30'd0, b_occ}, 32'd0);

        // ---------------- backpressure, B ----------------
        b_out_ready = 0; b_in_valid = 1;
        b_in_data = 1; check("bp_rdy1", {31'd0, b_in_ready}, 32'd1); step();
        b_in_data = 2; check("bp_rdy2", {31'd0, b_in_ready}, 32'd1); step();
        b_in_data = 3; check("bp_rdy3", {31'd0, b_in_ready}, 32'd1); step();
        b_in_valid = 0;
        check("bp_full_rdy", {31'd0, b_in_ready}, 32'd0);
        check("bp_full_occ", {30'd0, b_occ}, 32'd3);
        check("bp_head", b_out_data, 32'd1);
        step();
        check("bp_hold_head", b_out_data, 32'd1);
        check("bp_hold_occ", {30'd0, b_occ}, 32'd3);
        b_out_ready = 1;
        step();
        check("bp_out2", b_out_data, 32'd2);
        check("bp_out2_occ", {30'd0, b_occ}, 32'd2);
        check("bp_out2_rdy", {31'd0, b_in_ready}, 32'd1);
        step();
        check("bp_out3", b_out_data, 32'd3);
        check("bp_out3_valid", {31'd0, b_out_valid}, 32'd1);
        step();
        check("bp_done_valid", {31'd0, b_out_valid}, 32'd0);
        check("bp_done_occ", {30'd0, b_occ}, 32'd0);

        // ---------------- async reset, B ----------------
        b_out_ready = 0; b_in_valid = 1;
        b_in_data = 32'h21; step();
        b_in_data = 32'h22; step();
        b_in_valid = 0;
        check("ar_pre_occ", {30'd0, b_occ}, 32'd2);
        #2;
        b_rst_n = 0;
        #1;
        check("ar_valid", {31'd0, b_out_valid}, 32'd0);
        check("ar_occ", {30'd0, b_occ}, 32'd0);
        check("ar_rdy", {31'd0, b_in_ready}, 32'd0);
        #2;
        b_rst_n = 1;
        step();
        check("ar_rel_rdy", {31'd0, b_in_ready}, 32'd1);
        check("ar_rel_valid", {31'd0, b_out_valid}, 32'd0);
        b_out_ready = 1; b_in_valid = 1; b_in_data = 32'hBEEF;
        step();
        b_in_valid = 0;
        check("ar_lat1_valid", {31'd0, b_out_valid}, 32'd0);
        step();
        check("ar_lat2_valid", {31'd0, b_out_valid}, 32'd1);
        check("ar_lat2_data", b_out_data, 32'hBEEF);

        // ---------------- bubble collapse, C ----------------
        c_out_ready = 0; c_in_valid = 1; c_in_data = 7;
        #1;
        check("bc_rdy7", {31'd0, c_in_ready}, 32'd1);
        step();
        c_in_valid = 0;
        step();
        c_in_valid = 1; c_in_data = 8;
        #1;
        check("bc_rdy8", {31'd0, c_in_ready}, 32'd1);
        step();
        c_in_valid = 0;
        #1;
        check("bc_occ_a", {29'd0, c_occ}, 32'd2);
        check("bc_head", c_out_data, 32'd7);
        step();
        check("bc_occ_b", {29'd0, c_occ}, 32'd2);
        check("bc_rdy_after", {31'd0, c_in_ready}, 32'd1);
        check("bc_head_b", c_out_data, 32'd7);

        // ---------------- overflow checker, C ----------------
        c_in_valid = 1; c_in_data = 9;
        #1;
        check("ov_rdy9", {31'd0, c_in_ready}, 32'd1);
        step();
        c_in_data = 10;
        #1;
        check("ov_full_rdy", {31'd0, c_in_ready}, 32'd0);
        check("ov_full_occ", {29'd0, c_occ}, 32'd3);
        step();
        check("ov_stall_ovf", {31'd0, c_ovf}, 32'd0);
        c_in_data = 11;
        step();
        c_in_valid = 0;
        check("ov_set", {31'd0, c_ovf}, 32'd1);
        check("ov_head", c_out_data, 32'd7);
        check("ov_occ", {29'd0, c_occ}, 32'd3);
        step();
        check("ov_sticky", {31'd0, c_ovf}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
